// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low segment
// patterns {g,f,e,d,c,b,a} and the scan state encoding.
package seg7_pkg;

  typedef enum logic {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Nibble to segment lookup.
  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: one digit per my_clk rise,
// all-off gap before each digit, display value snapshotted at each digit-0 entry.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    my_clk,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [2:0]              digit_idx
);

  localparam logic [2:0]            LAST_IDX = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]            GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] AN_BIT0  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [2:0]              sync_q, sync_d;
  state_e                  state_q, state_d;
  logic [7:0]              gap_cnt_q, gap_cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_value_q, snap_value_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_n_q, dp_n_d;

  logic                    tick_s;
  logic [4*NUM_DIGITS-1:0] value_shift_s;
  logic [NUM_DIGITS-1:0]   dp_shift_s;
  logic [NUM_DIGITS-1:0]   blank_shift_s;
  logic [3:0]              nib_s;
  logic [6:0]              dec_seg_s;
  logic                    lit_s;

  // sync_q[0] is the first capture flop; tick fires one cycle per my_clk rise.
  assign sync_d = {sync_q[1:0], my_clk};
  assign tick_s = sync_q[1] & ~sync_q[2];

  // Scan sequencing: gap countdown, digit advance and frame snapshot.
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    idx_d        = idx_q;
    snap_value_d = snap_value_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    case (state_q)
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_ON;
          gap_cnt_d = 8'd0;
          if (idx_q == 3'd0) begin
            snap_value_d = value;
            snap_dp_d    = dp;
            snap_blank_d = blank;
          end else begin
            snap_value_d = snap_value_q;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      ST_ON: begin
        if (tick_s) begin
          state_d = ST_GAP;
          idx_d   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        end else begin
          state_d = ST_ON;
        end
      end
      default: begin
        state_d   = ST_GAP;
        gap_cnt_d = 8'd0;
      end
    endcase
  end

  // Outputs follow the next state so they change on the same edge as it.
  always_comb begin
    value_shift_s = snap_value_d >> {idx_d, 2'b00};
    dp_shift_s    = snap_dp_d >> idx_d;
    blank_shift_s = snap_blank_d >> idx_d;
    nib_s         = value_shift_s[3:0];
    lit_s         = (state_d == ST_ON) && !blank_shift_s[0];
    if (lit_s) begin
      an_d   = ~(AN_BIT0 << idx_d);
      seg_d  = dec_seg_s;
      dp_n_d = ~dp_shift_s[0];
    end else begin
      an_d   = AN_OFF;
      seg_d  = SEG_OFF;
      dp_n_d = 1'b1;
    end
  end

  seg7_hex_decode u_hex_decode (
    .nib (nib_s),
    .seg (dec_seg_s)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= 3'b000;
      state_q      <= ST_GAP;
      gap_cnt_q    <= 8'd0;
      idx_q        <= 3'd0;
      snap_value_q <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_n_q       <= 1'b1;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      idx_q        <= idx_d;
      snap_value_q <= snap_value_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp_n      = dp_n_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: directed scan scenarios plus randomized my_clk/value
// traffic, compared every cycle against a behavioural display model.
module tb_seg7_scan_driver;

  localparam int N   = 4;
  localparam int GAP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        my_clk = 1'b0;
  logic [15:0] value = 16'h1234;
  logic [3:0]  dp = 4'b0000;
  logic [3:0]  blank = 4'b0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic [2:0]  digit_idx;

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] hex_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model: which digit is lit (if any), cycles left in the gap, frame snapshot,
  // and the my_clk level seen at the last three clk edges (index 0 newest).
  bit          m_on;
  int          m_gap_left;
  int          m_digit;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  bit          hist[$];

  seg7_scan_driver #(.NUM_DIGITS(N), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .my_clk    (my_clk),
    .value     (value),
    .dp        (dp),
    .blank     (blank),
    .an        (an),
    .seg       (seg),
    .dp_n      (dp_n),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_on       = 1'b0;
    m_gap_left = GAP;
    m_digit    = 0;
    m_val      = 16'h0000;
    m_dp       = 4'b0000;
    m_blank    = 4'b0000;
    hist       = '{1'b0, 1'b0, 1'b0};
  endfunction

  // A rise seen at edge e-2 (low at e-3) is acted on at edge e.
  function automatic void model_edge();
    bit tick;
    tick = hist[1] && !hist[2];
    hist.push_front(my_clk);
    void'(hist.pop_back());
    if (!m_on) begin
      m_gap_left = m_gap_left - 1;
      if (m_gap_left == 0) begin
        m_on       = 1'b1;
        m_gap_left = GAP;
        if (m_digit == 0) begin
          m_val   = value;
          m_dp    = dp;
          m_blank = blank;
        end
      end
    end else if (tick) begin
      m_on    = 1'b0;
      m_digit = (m_digit + 1) % N;
    end
  endfunction

  function automatic bit exp_lit();
    return m_on && !m_blank[m_digit];
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] one;
    one = 4'b0001;
    return exp_lit() ? ~(one << m_digit) : 4'b1111;
  endfunction

  function automatic logic [6:0] exp_seg();
    return exp_lit() ? hex_tbl[(m_val >> (4 * m_digit)) & 16'h000F] : 7'h7F;
  endfunction

  function automatic logic exp_dpn();
    return exp_lit() ? !m_dp[m_digit] : 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // One clk cycle: advance the model at the edge, compare at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    chk("an", 32'(an), 32'(exp_an()));
    chk("seg", 32'(seg), 32'(exp_seg()));
    chk("dp_n", 32'(dp_n), 32'(exp_dpn()));
    chk("digit_idx", 32'(digit_idx), 32'(m_digit));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse();
    my_clk = 1'b1;
    steps(12);
    my_clk = 1'b0;
    steps(12);
  endtask

  logic [3:0] scan_an  [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [6:0] scan_seg [4] = '{7'b0110000, 7'b0100100, 7'b1111001, 7'b0011001};
  logic [2:0] scan_idx [4] = '{3'd1, 3'd2, 3'd3, 3'd0};

  initial begin
    model_reset();
    steps(3);
    chk("rst_an", 32'(an), 32'h0000_000F);
    chk("rst_seg", 32'(seg), 32'h0000_007F);
    chk("rst_dp_n", 32'(dp_n), 32'd1);
    chk("rst_idx", 32'(digit_idx), 32'd0);

    // First frame needs no tick: digit 0 lights after GAP cycles.
    rst = 1'b0;
    steps(7);
    chk("first_gap_an", 32'(an), 32'h0000_000F);
    step();
    chk("first_on_an", 32'(an), 32'h0000_000E);
    chk("first_on_seg", 32'(seg), 32'(7'b0011001));
    chk("first_on_idx", 32'(digit_idx), 32'd0);
    steps(5);

    // Each my_clk rise: gap after 2 edges, next digit at 2+GAP edges.
    for (int d = 0; d < 4; d++) begin
      my_clk = 1'b1;
      steps(3);
      chk("scan_gap_an", 32'(an), 32'h0000_000F);
      chk("scan_gap_idx", 32'(digit_idx), 32'(scan_idx[d]));
      steps(7);
      chk("scan_pre_on_an", 32'(an), 32'h0000_000F);
      step();
      chk("scan_on_an", 32'(an), 32'(scan_an[d]));
      chk("scan_on_seg", 32'(seg), 32'(scan_seg[d]));
      step();
      my_clk = 1'b0;
      steps(12);
    end

    // Value changes mid-frame only land at the next digit-0 entry.
    pulse();
    pulse();
    value = 16'hABCD;
    step();
    chk("tear_d2_seg", 32'(seg), 32'(7'b0100100));
    pulse();
    chk("tear_d3_seg", 32'(seg), 32'(7'b1111001));
    pulse();
    chk("tear_d0_an", 32'(an), 32'h0000_000E);
    chk("tear_d0_seg", 32'(seg), 32'(7'b0100001));

    blank = 4'b0010;
    dp    = 4'b0001;
    pulse();
    chk("old_snap_d1_an", 32'(an), 32'h0000_000D);
    chk("old_snap_d1_seg", 32'(seg), 32'(7'b1000110));
    pulse();
    pulse();
    pulse();
    chk("dp_d0_an", 32'(an), 32'h0000_000E);
    chk("dp_d0_dp_n", 32'(dp_n), 32'd0);
    pulse();
    chk("blank_d1_an", 32'(an), 32'h0000_000F);
    chk("blank_d1_seg", 32'(seg), 32'h0000_007F);
    chk("blank_d1_dp_n", 32'(dp_n), 32'd1);
    chk("blank_d1_idx", 32'(digit_idx), 32'd1);
    pulse();
    chk("d2_dp_n", 32'(dp_n), 32'd1);
    chk("d2_an", 32'(an), 32'h0000_000B);

    // Second rise lands three cycles into the gap and must be dropped.
    my_clk = 1'b1;
    steps(2);
    my_clk = 1'b0;
    step();
    my_clk = 1'b1;
    steps(8);
    chk("drop_on_an", 32'(an), 32'h0000_0007);
    chk("drop_on_idx", 32'(digit_idx), 32'd3);
    steps(10);
    chk("drop_hold_an", 32'(an), 32'h0000_0007);
    chk("drop_hold_idx", 32'(digit_idx), 32'd3);
    my_clk = 1'b0;
    steps(4);

    // Randomized my_clk phases and display contents.
    for (int r = 0; r < 150; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        value = 16'($urandom);
        dp    = 4'($urandom);
        blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      end
      my_clk = 1'b1;
      steps($urandom_range(1, 20));
      my_clk = 1'b0;
      steps($urandom_range(1, 20));
    end

    // Asynchronous reset while a digit is lit.
    value = 16'h5678;
    dp    = 4'b0000;
    blank = 4'b0000;
    for (int i = 0; i < 40 && an == 4'hF; i++) step();
    chk("lit_before_rst", 32'(an != 4'hF), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_an", 32'(an), 32'h0000_000F);
    chk("async_rst_seg", 32'(seg), 32'h0000_007F);
    chk("async_rst_dp_n", 32'(dp_n), 32'd1);
    chk("async_rst_idx", 32'(digit_idx), 32'd0);
    model_reset();
    steps(2);
    rst = 1'b0;
    steps(7);
    chk("restart_gap_an", 32'(an), 32'h0000_000F);
    step();
    chk("restart_an", 32'(an), 32'h0000_000E);
    chk("restart_seg", 32'(seg), 32'(7'b0000000));
    chk("restart_idx", 32'(digit_idx), 32'd0);
    steps(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
